field_tag_decoder: RTL and testbench

FIELD_TAG_DECODER -- requirements
Module: field_tag_decoder

---
 rtl/user_tree_pkg.sv | 4 +
 rtl/field_tag_decoder.sv | 176 +++++++++++++++++
 tb/tb_field_tag_decoder.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/user_tree_pkg.sv
// Shared types for the node-tree side of the message parser.
package user_tree_pkg;
    typedef logic [7:0] identifier;
endpackage

// File: rtl/field_tag_decoder.sv
// Streaming protobuf-style field tag decoder: extracts field number / wire type and skips payloads.
// Optional macro FIELD_TAG_DECODER_ERR_RECOVER_EN adds err_clr_i to leave ERROR without reset.
//
// state       | meaning
// TAG         | accumulating tag varint
// SKIP_VARINT | dropping a wire-type-0 varint payload
// SKIP_FIXED  | dropping 8 (wt 1) or 4 (wt 5) payload bytes
// LEN         | accumulating wire-type-2 length varint
// SKIP_BYTES  | dropping length-delimited payload
// ERROR       | protocol error, bytes dropped
module field_tag_decoder #(
    parameter int TAG_MAX_BYTES = 5,
    parameter int LEN_W         = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [7:0]                byte_i,
    input  logic                      byte_valid_i,
`ifdef FIELD_TAG_DECODER_ERR_RECOVER_EN
    input  logic                      err_clr_i,
`endif
    output logic                      byte_ready_o,
    output user_tree_pkg::identifier  field_id,
    output logic                      field_id_valid,
    output logic [2:0]                wire_type_o,
    output logic [LEN_W-1:0]          field_len_o,
    output logic                      field_len_valid_o,
    output logic                      err_o
);

    localparam int LEN_BYTES = (LEN_W + 6) / 7;
    localparam int ACC_W     = (TAG_MAX_BYTES > LEN_BYTES) ? 7 * TAG_MAX_BYTES : 7 * LEN_BYTES;
    localparam int IDX_W     = $clog2(ACC_W / 7 + 1);
    localparam int CNT_W     = (LEN_W > 4) ? LEN_W : 4;

    typedef enum logic [2:0] {
        TAG, SKIP_VARINT, SKIP_FIXED, LEN, SKIP_BYTES, ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         field_id_q, field_id_d;
    logic [2:0]         wire_type_q, wire_type_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               id_vld_q, id_vld_d;
    logic               len_vld_q, len_vld_d;

    logic               accept;
    logic [IDX_W+2:0]   shamt;
    logic [ACC_W-1:0]   acc_nxt;
    logic               fnum_zero, fnum_big, bad_wt, len_ovf, last_tag, last_len;

    // Ready is low exactly while reset is held, high in every state otherwise.
    assign byte_ready_o = reset_i;
    assign accept       = byte_valid_i & byte_ready_o;

    assign shamt     = {idx_q, 3'b000} - {3'b000, idx_q};
    assign acc_nxt   = acc_q | (ACC_W'(byte_i[6:0]) << shamt);
    assign fnum_zero = ((acc_nxt >> 3) == '0);
    assign fnum_big  = ((acc_nxt >> 11) != '0);
    assign bad_wt    = (acc_nxt[2:0] == 3'd3) || (acc_nxt[2:0] == 3'd4) ||
                       (acc_nxt[2:0] == 3'd6) || (acc_nxt[2:0] == 3'd7);
    assign len_ovf   = ((acc_nxt >> LEN_W) != '0);
    assign last_tag  = (idx_q == IDX_W'(TAG_MAX_BYTES - 1));
    assign last_len  = (idx_q == IDX_W'(LEN_BYTES - 1));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        field_id_d  = field_id_q;
        wire_type_d = wire_type_q;
        len_d       = len_q;
        id_vld_d    = 1'b0;
        len_vld_d   = 1'b0;
        if (accept) begin
            case (state_q)
                TAG: begin
                    if (byte_i[7]) begin
                        if (last_tag) begin
                            state_d = ERROR;
                        end else begin
                            acc_d = acc_nxt;
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        acc_d = '0;
                        idx_d = '0;
                        if (fnum_zero || fnum_big || bad_wt) begin
                            state_d = ERROR;
                        end else begin
                            field_id_d  = acc_nxt[10:3];
                            wire_type_d = acc_nxt[2:0];
                            id_vld_d    = 1'b1;
                            case (acc_nxt[2:0])
                                3'd0:    state_d = SKIP_VARINT;
                                3'd1:    begin state_d = SKIP_FIXED; cnt_d = CNT_W'(8); end
                                3'd5:    begin state_d = SKIP_FIXED; cnt_d = CNT_W'(4); end
                                default: state_d = LEN;
                            endcase
                        end
                    end
                end
                SKIP_VARINT: begin
                    if (!byte_i[7]) state_d = TAG;
                end
                SKIP_FIXED, SKIP_BYTES: begin
                    if (cnt_q == CNT_W'(1)) state_d = TAG;
                    else                    cnt_d   = cnt_q - CNT_W'(1);
                end
                LEN: begin
                    if (len_ovf || (byte_i[7] && last_len)) begin
                        state_d = ERROR;
                    end else if (byte_i[7]) begin
                        acc_d = acc_nxt;
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        acc_d     = '0;
                        idx_d     = '0;
                        len_d     = acc_nxt[LEN_W-1:0];
                        len_vld_d = 1'b1;
                        if (acc_nxt[LEN_W-1:0] == '0) begin
                            state_d = TAG;
                        end else begin
                            state_d = SKIP_BYTES;
                            cnt_d   = CNT_W'(acc_nxt[LEN_W-1:0]);
                        end
                    end
                end
                default: ;
            endcase
        end
`ifdef FIELD_TAG_DECODER_ERR_RECOVER_EN
        if ((state_q == ERROR) && err_clr_i) begin
            state_d = TAG;
            acc_d   = '0;
            idx_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= TAG;
            acc_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            field_id_q  <= '0;
            wire_type_q <= '0;
            len_q       <= '0;
            id_vld_q    <= 1'b0;
            len_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            field_id_q  <= field_id_d;
            wire_type_q <= wire_type_d;
            len_q       <= len_d;
            id_vld_q    <= id_vld_d;
            len_vld_q   <= len_vld_d;
        end
    end

    assign field_id          = field_id_q;
    assign field_id_valid    = id_vld_q;
    assign wire_type_o       = wire_type_q;
    assign field_len_o       = len_q;
    assign field_len_valid_o = len_vld_q;
    assign err_o             = (state_q == ERROR);

endmodule

// File: tb/tb_field_tag_decoder.sv
// Bench for field_tag_decoder: directed and random byte streams against a stream-level parser model.
module tb_field_tag_decoder;

    localparam int TAG_MAX   = 5;
    localparam int LEN_W     = 16;
    localparam int LEN_BYTES = 3;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        int     kind;   // 0 = field tag, 1 = length
        int     idx;    // stream position of the byte that completed it
        longint v1;
        longint v2;
    } ev_t;

    logic                     clk_i = 1'b0;
    logic                     reset_i;
    logic [7:0]               byte_i;
    logic                     byte_valid_i;
`ifdef FIELD_TAG_DECODER_ERR_RECOVER_EN
    logic                     err_clr_i;
`endif
    logic                     byte_ready_o;
    user_tree_pkg::identifier field_id;
    logic                     field_id_valid;
    logic [2:0]               wire_type_o;
    logic [LEN_W-1:0]         field_len_o;
    logic                     field_len_valid_o;
    logic                     err_o;

    always #5 clk_i = ~clk_i;

    field_tag_decoder #(.TAG_MAX_BYTES(TAG_MAX), .LEN_W(LEN_W)) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .byte_i            (byte_i),
        .byte_valid_i      (byte_valid_i),
`ifdef FIELD_TAG_DECODER_ERR_RECOVER_EN
        .err_clr_i         (err_clr_i),
`endif
        .byte_ready_o      (byte_ready_o),
        .field_id          (field_id),
        .field_id_valid    (field_id_valid),
        .wire_type_o       (wire_type_o),
        .field_len_o       (field_len_o),
        .field_len_valid_o (field_len_valid_o),
        .err_o             (err_o)
    );

    int      total = 0;
    int      bad   = 0;
    ev_t     obs_q[$];
    ev_t     exp_q[$];
    int      obs_err;
    int      exp_err;
    int      nacc;
    byte_q_t gq;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, count the handshake, sample outputs at the next negedge.
    task automatic step(input logic v, input logic [7:0] b);
        logic acc_now;
        byte_valid_i = v;
        byte_i       = b;
        acc_now      = v && byte_ready_o;
        @(negedge clk_i);
        if (acc_now) nacc++;
        if (field_id_valid || field_len_valid_o)
            check_eq("pulse_excl", longint'(field_id_valid & field_len_valid_o), 0);
        if (field_id_valid)    obs_q.push_back('{0, nacc - 1, longint'(field_id), longint'(wire_type_o)});
        if (field_len_valid_o) obs_q.push_back('{1, nacc - 1, longint'(field_len_o), 0});
        if (err_o && obs_err < 0) obs_err = nacc - 1;
    endtask

    task automatic apply_reset();
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
        reset_i      = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
    endtask

    // Reference: parse the whole stream by the message rules, listing fields, lengths and the error point.
    task automatic model(input byte_q_t s);
        int p, n, k;
        longint v, fnum, wt;
        logic [7:0] b;
        exp_q.delete();
        exp_err = -1;
        p = 0;
        n = s.size();
        while (p < n) begin
            v = 0; k = 0;
            forever begin
                if (p >= n) return;
                b = s[p];
                v = v + (longint'(b & 8'h7f) << (7 * k));
                k++;
                if (!b[7]) break;
                if (k >= TAG_MAX) begin exp_err = p; return; end
                p++;
            end
            fnum = v / 8;
            wt   = v % 8;
            if (fnum == 0 || fnum > 255 || !(wt inside {0, 1, 2, 5})) begin
                exp_err = p;
                return;
            end
            exp_q.push_back('{0, p, fnum, wt});
            p++;
            if (wt == 0) begin
                while (p < n) begin
                    b = s[p];
                    p++;
                    if (!b[7]) break;
                end
            end else if (wt == 1) begin
                p += 8;
            end else if (wt == 5) begin
                p += 4;
            end else begin
                v = 0; k = 0;
                forever begin
                    if (p >= n) return;
                    b = s[p];
                    v = v + (longint'(b & 8'h7f) << (7 * k));
                    k++;
                    if (v >= (longint'(1) << LEN_W)) begin exp_err = p; return; end
                    if (!b[7]) break;
                    if (k >= LEN_BYTES) begin exp_err = p; return; end
                    p++;
                end
                exp_q.push_back('{1, p, v, 0});
                p = p + 1 + int'(v);
            end
        end
    endtask

    task automatic run(input string name, input byte_q_t s, input bit do_reset, input bit gaps);
        int lim;
        if (do_reset) apply_reset();
        obs_q.delete();
        obs_err = -1;
        nacc    = 0;
        foreach (s[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) step(1'b0, 8'h00);
            step(1'b1, s[i]);
        end
        repeat (3) step(1'b0, 8'h00);
        model(s);
        check_eq({name, ".nev"}, obs_q.size(), exp_q.size());
        lim = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++) begin
            check_eq({name, ".kind"}, obs_q[i].kind, exp_q[i].kind);
            check_eq({name, ".idx"},  obs_q[i].idx,  exp_q[i].idx);
            check_eq({name, ".val"},  obs_q[i].v1,   exp_q[i].v1);
            check_eq({name, ".wt"},   obs_q[i].v2,   exp_q[i].v2);
        end
        check_eq({name, ".err_at"}, obs_err, exp_err);
        check_eq({name, ".err_end"}, err_o, (exp_err >= 0) ? 1 : 0);
        check_eq({name, ".ready"}, byte_ready_o, 1);
    endtask

    task automatic push_varint(input longint v, input int extra);
        int g;
        longint t;
        logic [7:0] b;
        g = 1;
        t = v >> 7;
        while (t != 0) begin g++; t = t >> 7; end
        g += extra;
        for (int i = 0; i < g; i++) begin
            b = 8'(v >> (7 * i)) & 8'h7f;
            if (i < g - 1) b = b | 8'h80;
            gq.push_back(b);
        end
    endtask

    task automatic gen_stream();
        int r, nf;
        longint fnum, wt, len;
        gq.delete();
        nf = $urandom_range(2, 6);
        for (int f = 0; f < nf; f++) begin
            r    = $urandom_range(0, 24);
            fnum = $urandom_range(1, 255);
            if (r == 0) fnum = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(256, 400);
            case ($urandom_range(0, 3))
                0: wt = 0;
                1: wt = 1;
                2: wt = 2;
                default: wt = 5;
            endcase
            if (r == 1) begin
                case ($urandom_range(0, 3))
                    0: wt = 3;
                    1: wt = 4;
                    2: wt = 6;
                    default: wt = 7;
                endcase
            end
            push_varint(fnum * 8 + wt, (r == 2) ? $urandom_range(0, 5) : 0);
            case (wt)
                0: push_varint($urandom_range(0, 1 << 21), 0);
                1: repeat (8) gq.push_back(8'($urandom));
                2: begin
                    len = (r == 3) ? $urandom_range(65536, 100000) : $urandom_range(0, 6);
                    push_varint(len, (r == 4) ? 1 : 0);
                    if (len < 65536) repeat (int'(len)) gq.push_back(8'($urandom));
                end
                default: repeat (4) gq.push_back(8'($urandom));
            endcase
        end
    endtask

    initial begin
        reset_i      = 1'b0;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
`ifdef FIELD_TAG_DECODER_ERR_RECOVER_EN
        err_clr_i    = 1'b0;
`endif
        @(negedge clk_i);
        check_eq("rst.ready",  byte_ready_o, 0);
        check_eq("rst.fid",    field_id, 0);
        check_eq("rst.fidv",   field_id_valid, 0);
        check_eq("rst.err",    err_o, 0);

        gq = '{8'h08, 8'h96, 8'h01};
        run("varint", gq, 1'b1, 1'b0);
        check_eq("varint.hold_id", field_id, 1);
        check_eq("varint.hold_wt", wire_type_o, 0);

        gq = '{8'h12, 8'h03, 8'h41, 8'h42, 8'h43, 8'h18, 8'h05};
        run("lendelim", gq, 1'b1, 1'b0);
        check_eq("lendelim.len", field_len_o, 3);
        check_eq("lendelim.id",  field_id, 3);

        gq = '{8'h0D, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h09, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18,
               8'h10, 8'h00, 8'h12, 8'h00, 8'h08, 8'h01};
        run("fixed", gq, 1'b1, 1'b0);
        check_eq("fixed.len0", field_len_o, 0);

        gq = '{8'h80, 8'h08, 8'h01};
        run("fid128", gq, 1'b1, 1'b0);
        check_eq("fid128.id", field_id, 128);

        gq = '{8'h80, 8'h10, 8'h08, 8'h01};
        run("fid256", gq, 1'b1, 1'b0);
        check_eq("fid256.err", err_o, 1);

        gq = '{8'h0B, 8'h08, 8'h01, 8'h10, 8'h00};
        run("wt3", gq, 1'b1, 1'b0);
        check_eq("wt3.err", err_o, 1);
`ifdef FIELD_TAG_DECODER_ERR_RECOVER_EN
        err_clr_i = 1'b1;
        step(1'b0, 8'h00);
        err_clr_i = 1'b0;
        check_eq("clr.err", err_o, 0);
        gq = '{8'h08, 8'h01};
        run("clr", gq, 1'b0, 1'b0);
        check_eq("clr.id", field_id, 1);
`endif

        // Reset in the middle of a length-delimited payload.
        apply_reset();
        step(1'b1, 8'h12);
        step(1'b1, 8'h05);
        step(1'b1, 8'h41);
        byte_valid_i = 1'b0;
        reset_i      = 1'b0;
        #1;
        check_eq("midrst.ready", byte_ready_o, 0);
        check_eq("midrst.fid",   field_id, 0);
        check_eq("midrst.wt",    wire_type_o, 0);
        check_eq("midrst.len",   field_len_o, 0);
        check_eq("midrst.fidv",  field_id_valid, 0);
        check_eq("midrst.lenv",  field_len_valid_o, 0);
        check_eq("midrst.err",   err_o, 0);
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        gq = '{8'h08, 8'h01};
        run("midrst", gq, 1'b0, 1'b0);
        check_eq("midrst.id", field_id, 1);

        for (int t = 0; t < 40; t++) begin
            gen_stream();
            run("rand", gq, 1'b1, t[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
